// File: rtl/rl_pkg.sv
// rtl/rl_pkg.sv - shared parameters and state encoding for the pair scheduler
package rl_pkg;

  localparam int RL_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rl_state_t;

endpackage

// File: rtl/rl_pair_addr_counter.sv
// rtl/rl_pair_addr_counter.sv - row-major wrapping (home, neighbor) index walker
module rl_pair_addr_counter
  import rl_pkg::*;
#(
  parameter int ADDR_WIDTH = RL_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [ADDR_WIDTH:0]   home_limit,
  input  logic [ADDR_WIDTH:0]   neighbor_limit,
  output logic [ADDR_WIDTH-1:0] home_idx,
  output logic [ADDR_WIDTH-1:0] neighbor_idx,
  output logic                  last
);

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] home_max;
  logic [ADDR_WIDTH:0] neighbor_max;
  logic                home_wrap;
  logic                neighbor_wrap;

  // Detect the top index of each dimension; limits are counts, so the top index is limit-1
  always_comb begin
    home_max      = home_limit - ONE;
    neighbor_max  = neighbor_limit - ONE;
    home_wrap     = ({1'b0, home_idx} == home_max);
    neighbor_wrap = ({1'b0, neighbor_idx} == neighbor_max);
    last          = home_wrap && neighbor_wrap;
  end

  // Neighbor is the fast index; both wrap to zero after the final pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_idx     <= '0;
      neighbor_idx <= '0;
    end else if (clear) begin
      home_idx     <= '0;
      neighbor_idx <= '0;
    end else if (advance) begin
      if (neighbor_wrap) begin
        neighbor_idx <= '0;
        home_idx     <= home_wrap ? '0 : home_idx + 1'b1;
      end else begin
        neighbor_idx <= neighbor_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rl_pair_scheduler.sv
// rtl/rl_pair_scheduler.sv - issues home/neighbor BRAM read pairs and tracks outstanding forces
module rl_pair_scheduler
  import rl_pkg::*;
#(
  parameter int ADDR_WIDTH = RL_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 2*ADDR_WIDTH+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   home_num,
  input  logic [ADDR_WIDTH:0]   neighbor_num,
  input  logic                  skip_self,
  input  logic                  stall,
  input  logic                  force_valid,
  output logic [ADDR_WIDTH-1:0] home_rdaddr,
  output logic [ADDR_WIDTH-1:0] neighbor_rdaddr,
  output logic                  rden,
  output logic                  r2_enable,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pair_count
);

  rl_state_t             state;
  rl_state_t             state_next;
  logic [ADDR_WIDTH:0]   home_lat;
  logic [ADDR_WIDTH:0]   neighbor_lat;
  logic                  skip_lat;
  logic [ADDR_WIDTH:0]   home_lim;
  logic [ADDR_WIDTH:0]   neighbor_lim;
  logic                  skip_eff;
  logic [ADDR_WIDTH-1:0] home_idx;
  logic [ADDR_WIDTH-1:0] neighbor_idx;
  logic                  idx_last;
  logic [CNT_WIDTH-1:0]  outstanding;
  logic                  presented_last;
  logic                  start_go;
  logic                  empty_req;
  logic                  step;
  logic                  skip_hit;
  logic                  idx_clear;
  logic                  force_eff;

  // In IDLE the live inputs drive the walker so pair (0,0) can be stepped on the start edge
  always_comb begin
    start_go     = (state == ST_IDLE) && start && !abort;
    home_lim     = (state == ST_IDLE) ? home_num : home_lat;
    neighbor_lim = (state == ST_IDLE) ? neighbor_num : neighbor_lat;
    skip_eff     = (state == ST_IDLE) ? skip_self : skip_lat;
    empty_req    = (home_num == '0) || (neighbor_num == '0);
    step         = !abort && !stall &&
                   ((start_go && !empty_req) || ((state == ST_RUN) && !presented_last));
    skip_hit     = skip_eff && (home_idx == neighbor_idx);
    idx_clear    = abort || ((state != ST_RUN) && !step);
    force_eff    = force_valid && ((state == ST_RUN) || (state == ST_DRAIN));
  end

  rl_pair_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_counter (
    .clk           (clk),
    .rst           (rst),
    .advance       (step),
    .clear         (idx_clear),
    .home_limit    (home_lim),
    .neighbor_limit(neighbor_lim),
    .home_idx      (home_idx),
    .neighbor_idx  (neighbor_idx),
    .last          (idx_last)
  );

  // Next-state decode; abort overrides everything
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_go) state_next = empty_req ? ST_DONE : ST_RUN;
      ST_RUN:   if (presented_last) state_next = ST_DRAIN;
      ST_DRAIN: if ((outstanding == '0) && !r2_enable) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Pass configuration captured on an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_lat     <= '0;
      neighbor_lat <= '0;
      skip_lat     <= 1'b0;
    end else if (start_go) begin
      home_lat     <= home_num;
      neighbor_lat <= neighbor_num;
      skip_lat     <= skip_self;
    end
  end

  // Registered pair presentation; a skipped pair still consumes its step but raises no rden
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_rdaddr     <= '0;
      neighbor_rdaddr <= '0;
      rden            <= 1'b0;
      r2_enable       <= 1'b0;
      presented_last  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      rden           <= step && !skip_hit;
      r2_enable      <= rden;
      presented_last <= step && idx_last;
      busy           <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
      done           <= (state == ST_DONE) && !abort;
      if (step) begin
        home_rdaddr     <= home_idx;
        neighbor_rdaddr <= neighbor_idx;
      end else if (start_go) begin
        home_rdaddr     <= '0;
        neighbor_rdaddr <= '0;
      end
    end
  end

  // Issued-pair and in-flight force bookkeeping; outstanding floors at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_count  <= '0;
      outstanding <= '0;
    end else begin
      if (start_go)  pair_count <= '0;
      else if (rden) pair_count <= pair_count + 1'b1;

      if (start_go || abort)                             outstanding <= '0;
      else if (rden && !force_eff)                       outstanding <= outstanding + 1'b1;
      else if (!rden && force_eff && outstanding != '0)  outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// tb/tb_rl_pair_scheduler.sv - randomized and directed check of rl_pair_scheduler against a pass-level model
module tb_rl_pair_scheduler;

  localparam int AW = 3;
  localparam int CW = 2*AW+1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW:0]   home_num;
  logic [AW:0]   neighbor_num;
  logic          skip_self;
  logic          stall;
  logic          force_valid;
  logic [AW-1:0] home_rdaddr;
  logic [AW-1:0] neighbor_rdaddr;
  logic          rden;
  logic          r2_enable;
  logic          busy;
  logic          done;
  logic [CW-1:0] pair_count;

  always #5 clk = ~clk;

  rl_pair_scheduler #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .home_num       (home_num),
    .neighbor_num   (neighbor_num),
    .skip_self      (skip_self),
    .stall          (stall),
    .force_valid    (force_valid),
    .home_rdaddr    (home_rdaddr),
    .neighbor_rdaddr(neighbor_rdaddr),
    .rden           (rden),
    .r2_enable      (r2_enable),
    .busy           (busy),
    .done           (done),
    .pair_count     (pair_count)
  );

  // Pass-level model: phase 0 idle, 1 issuing, 2 draining, 3 finishing
  int            ph = 0;
  int            m_h = 0;
  int            m_n = 0;
  int            k = 0;
  int            m_out = 0;
  bit            m_s = 0;
  logic [AW-1:0] e_h = '0;
  logic [AW-1:0] e_n = '0;
  logic          e_rden = 0;
  logic          e_r2 = 0;
  logic          e_busy = 0;
  logic          e_done = 0;
  logic [CW-1:0] e_cnt = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int fvq[$];
  int fv_lat = 25;
  bit spurious_en = 0;
  int done_seen = 0;
  int rden_seen = 0;
  int last_done_cyc = 0;
  int last_fv_cyc = 0;
  int first_rden_cyc = -1;
  int start_cyc = 0;
  int done0 = 0;
  int rden0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int  o;
    bit  fv_live;
    logic n_rden;
    logic n_done;
    if (!rst) begin
      ph = 0; k = 0; m_out = 0; m_h = 0; m_n = 0; m_s = 0;
      e_h = '0; e_n = '0; e_rden = 0; e_r2 = 0; e_busy = 0; e_done = 0; e_cnt = '0;
      return;
    end
    fv_live = force_valid && (ph == 1 || ph == 2);
    o = m_out;
    if (e_rden && !fv_live) o = o + 1;
    else if (!e_rden && fv_live && o > 0) o = o - 1;
    e_cnt = e_cnt + CW'(e_rden);
    n_rden = 0;
    n_done = 0;
    if (abort) begin
      ph = 0;
      o = 0;
    end else begin
      case (ph)
        0: if (start) begin
             m_h = int'(home_num); m_n = int'(neighbor_num); m_s = skip_self;
             e_cnt = '0; o = 0; k = 0; e_h = '0; e_n = '0;
             if (m_h == 0 || m_n == 0) ph = 3;
             else begin
               ph = 1;
               if (!stall) begin
                 e_h = AW'(k / m_n); e_n = AW'(k % m_n);
                 n_rden = !(m_s && (k / m_n == k % m_n));
                 k++;
               end
             end
           end
        1: if (k == m_h * m_n) ph = 2;
           else if (!stall) begin
             e_h = AW'(k / m_n); e_n = AW'(k % m_n);
             n_rden = !(m_s && (k / m_n == k % m_n));
             k++;
           end
        2: if (m_out == 0 && !e_r2) ph = 3;
        default: begin ph = 0; n_done = 1; end
      endcase
    end
    e_r2   = e_rden;
    e_rden = n_rden;
    e_done = n_done;
    e_busy = (ph == 1 || ph == 2);
    m_out  = o;
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("rst_rden", rden, 0);
      check("rst_r2_enable", r2_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pair_count", pair_count, 0);
      check("rst_home_rdaddr", home_rdaddr, 0);
      check("rst_neighbor_rdaddr", neighbor_rdaddr, 0);
    end else begin
      check("rden", rden, e_rden);
      check("r2_enable", r2_enable, e_r2);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pair_count", pair_count, e_cnt);
      check("home_rdaddr", home_rdaddr, e_h);
      check("neighbor_rdaddr", neighbor_rdaddr, e_n);
      if (done === 1'b1) begin done_seen++; last_done_cyc = cyc; end
      if (rden === 1'b1) begin
        rden_seen++;
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
      end
      if (r2_enable === 1'b1) fvq.push_back(cyc + fv_lat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    force_valid = 1'b0;
    if (fvq.size() > 0 && fvq[0] <= cyc) begin
      force_valid = 1'b1;
      void'(fvq.pop_front());
      last_fv_cyc = cyc;
    end
    if (spurious_en && $urandom_range(0, 39) == 0) force_valid = 1'b1;
  endtask

  task automatic start_pass(input int h, input int n, input bit s);
    home_num       = (AW+1)'(h);
    neighbor_num   = (AW+1)'(n);
    skip_self      = s;
    start          = 1'b1;
    start_cyc      = cyc;
    done0          = done_seen;
    rden0          = rden_seen;
    first_rden_cyc = -1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_seen == done0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_pulse"}, done_seen - done0, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; start = 0; abort = 0; home_num = '0; neighbor_num = '0;
    skip_self = 0; stall = 0; force_valid = 0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("idle_busy", busy, 0);
    check("idle_pair_count", pair_count, 0);

    // 4x4 full pass
    start_pass(4, 4, 0);
    wait_done("p4x4", 300);
    check("p4x4_first_rden_lat", first_rden_cyc - start_cyc, 1);
    check("p4x4_rden_cycles", rden_seen - rden0, 16);
    check("p4x4_pair_count", pair_count, 16);
    check("p4x4_done_after_fv", last_done_cyc - last_fv_cyc, 3);
    repeat (3) tick();
    check("p4x4_single_done", done_seen - done0, 1);
    check("p4x4_busy_after", busy, 0);

    // 4x4 with self pairs suppressed, plus an ignored start mid-pass
    start_pass(4, 4, 1);
    repeat (4) tick();
    home_num = 5'(2); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("p4x4s", 300);
    check("p4x4s_rden_cycles", rden_seen - rden0, 12);
    check("p4x4s_pair_count", pair_count, 12);

    // 2x3 with three stall cycles after the second pair
    start_pass(2, 3, 0);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_done("p2x3", 300);
    check("p2x3_rden_cycles", rden_seen - rden0, 6);
    check("p2x3_pair_count", pair_count, 6);
    check("p2x3_done_after_fv", last_done_cyc - last_fv_cyc, 3);

    // Empty passes
    start_pass(0, 3, 0);
    wait_done("p0", 20);
    check("p0_done_lat", last_done_cyc - start_cyc, 2);
    check("p0_rden_cycles", rden_seen - rden0, 0);
    start_pass(1, 1, 1);
    wait_done("p1x1s", 40);
    check("p1x1s_rden_cycles", rden_seen - rden0, 0);
    check("p1x1s_pair_count", pair_count, 0);

    // Abort on the fifth pair, then a clean pass
    start_pass(4, 4, 0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (40) tick();
    check("abort_no_done", done_seen - done0, 0);
    check("abort_rden_cycles", rden_seen - rden0, 5);
    check("abort_busy", busy, 0);
    start_pass(4, 4, 0);
    wait_done("post_abort", 300);
    check("post_abort_pair_count", pair_count, 16);

    // Reset on the fifth pair, then a clean pass
    start_pass(4, 4, 0);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("reset_no_done", done_seen - done0, 0);
    check("reset_pair_count", pair_count, 0);
    start_pass(4, 4, 0);
    wait_done("post_reset", 300);
    check("post_reset_pair_count", pair_count, 16);

    // Randomized traffic, every cycle checked against the model
    spurious_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) fv_lat = $urandom_range(1, 30);
      start        = ($urandom_range(0, 11) == 0);
      home_num     = (AW+1)'($urandom_range(0, 8));
      neighbor_num = (AW+1)'($urandom_range(0, 8));
      skip_self    = $urandom_range(0, 1);
      stall        = ($urandom_range(0, 3) == 0);
      abort        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end
    start = 0; abort = 0; stall = 0; spurious_en = 0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rl_pair_scheduler.md
RL_PAIR_SCHEDULER -- requirements
Module: rl_pair_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, BRAM address width (depth 2^ADDR_WIDTH).
REQ-002 SHALL have parameter CNT_WIDTH, default 2*ADDR_WIDTH+1, width of pair counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Port list:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a pass.
- abort  in  1  terminate the pass immediately.
- home_num  in  ADDR_WIDTH+1  home particle count, 0..2^ADDR_WIDTH.
- neighbor_num  in  ADDR_WIDTH+1  neighbor particle count, 0..2^ADDR_WIDTH.
- skip_self  in  1  suppress pairs where home index equals neighbor index.
- stall  in  1  downstream backpressure; no pair issued while high.
- force_valid  in  1  one completed force from the evaluation pipeline.
- home_rdaddr  out  ADDR_WIDTH  home (ref) BRAM read address.
- neighbor_rdaddr  out  ADDR_WIDTH  neighbor (pos) BRAM read address.
- rden  out  1  BRAM read enable; one pair issued per high cycle.
- r2_enable  out  1  rden delayed one cycle (BRAM read latency).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse.
- pair_count  out  CNT_WIDTH  pairs issued in current/last pass.

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-005 SHALL sample start only in IDLE; on start, latch home_num, neighbor_num and skip_self, clear addresses, pair_count and outstanding count.
REQ-006 SHALL go IDLE->DONE directly when either latched count is 0; otherwise IDLE->RUN.
REQ-007 In RUN, each cycle with stall low SHALL present the current (home, neighbor) pair and advance neighbor; at neighbor_num-1 it SHALL wrap neighbor to 0 and increment home.
REQ-008 In RUN, rden SHALL be 1 only when a pair is presented; with stall high, addresses SHALL hold and rden SHALL be 0.
REQ-009 With skip_self set and home==neighbor, the pair SHALL NOT be issued (rden 0); indices SHALL advance as if issued, consuming one cycle.
REQ-010 First rden SHALL occur the cycle after the start cycle; r2_enable SHALL equal rden delayed exactly one cycle.
REQ-011 After the pair (home_num-1, neighbor_num-1) is presented or skipped, RUN SHALL go to DRAIN.
REQ-012 pair_count SHALL increment on every rden=1 cycle. The CNT_WIDTH outstanding counter SHALL increment on rden and decrement on force_valid; simultaneous events SHALL leave it unchanged.
REQ-013 DRAIN SHALL go to DONE when outstanding is 0 and r2_enable is 0.
REQ-014 DONE SHALL assert done for exactly one cycle, then return to IDLE; pair_count SHALL hold until the next start.
REQ-015 force_valid in IDLE or DONE SHALL be ignored; outstanding underflow SHALL saturate at 0.
REQ-016 abort in any state SHALL force IDLE next cycle with rden=0 and no done pulse; abort has priority over start.
REQ-017 start while busy SHALL be ignored.

Reset
REQ-018 While rst is low, state SHALL be IDLE and all outputs 0 (addresses, rden, r2_enable, busy, done, pair_count); internal counters SHALL be cleared.
REQ-019 Reset assertion mid-pass SHALL abandon the pass with no done pulse; the first start after deassertion SHALL begin a clean pass.

Structure
REQ-020 State encoding and the ADDR_WIDTH default SHALL live in shared package rl_pkg.
REQ-021 The wrapping home/neighbor index pair SHALL be a sub-module, rl_pair_addr_counter (inputs: advance, clear, limits; outputs: indices, last).

Verification
REQ-022 home_num=4, neighbor_num=4, skip_self=0, no stall -> 16 rden cycles in row-major order starting the cycle after start; r2_enable lags rden by 1; pair_count=16.
REQ-023 The same pass with skip_self=1 -> 12 pairs issued; (0,0), (1,1), (2,2), (3,3) absent; 16 RUN cycles; pair_count=12.
REQ-024 home_num=2, neighbor_num=3, stall high for 3 cycles after the 2nd pair -> addresses hold, rden low for those 3 cycles; all 6 pairs issued once.
REQ-025 force_valid returned 25 cycles after each r2_enable -> done pulses once, exactly one cycle after the 6th force_valid's DRAIN exit condition; busy low afterwards.
REQ-026 home_num=0 -> done pulse 2 cycles after start, rden never high. home_num=neighbor_num=1 with skip_self=1 -> no rden, done pulses.
REQ-027 abort (or rst low) at the 5th pair of a 4x4 pass -> IDLE next cycle, no done pulse; a subsequent start completes a full 16-pair pass.
